mem_write_buffer: RTL and testbench

// Line-granular write-back buffer between the cache eviction path and the memory write port.

---
 rtl/mem_write_buffer.sv | 141 ++++++++++++++
 tb/tb_mem_write_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Line write-back buffer: queues evicted lines, merges same-line pushes,
// serves read-bypass lookups and drains one line at a time to memory.
module mem_write_buffer #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 128,
  parameter int OFFS_BITS = 4,
  parameter int DEPTH     = 4,
  parameter int PTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pushE,
  input  logic [ADDR_BITS-1:0] pushAddr,
  input  logic [LINE_BITS-1:0] pushData,
  output logic                 full,
  output logic                 empty,
  input  logic [ADDR_BITS-1:0] lookupAddr,
  output logic                 lookupHit,
  output logic [LINE_BITS-1:0] lookupData,
  output logic [ADDR_BITS-1:0] wAddr,
  output logic                 wE,
  output logic [LINE_BITS-1:0] wData,
  input  logic                 wDone
);

  localparam int TAG_BITS = ADDR_BITS - OFFS_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [TAG_BITS-1:0]  tag_q  [DEPTH];
  logic [LINE_BITS-1:0] data_q [DEPTH];
  logic [PTR_BITS-1:0]  head;
  logic [PTR_BITS-1:0]  tail;
  logic [PTR_BITS:0]    count;
  logic [PTR_BITS:0]    count_nx;

  logic [TAG_BITS-1:0]  push_tag;
  logic [TAG_BITS-1:0]  look_tag;
  logic                 merge;
  logic [PTR_BITS-1:0]  merge_idx;
  logic                 do_merge;
  logic                 do_new;
  logic                 pop;
  logic [LINE_BITS-1:0] head_data;

  assign push_tag = pushAddr[ADDR_BITS-1:OFFS_BITS];
  assign look_tag = lookupAddr[ADDR_BITS-1:OFFS_BITS];

  // Youngest mergeable entry; the in-flight head is never modified.
  always_comb begin
    merge     = 1'b0;
    merge_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PTR_BITS+1)'(k) < count &&
          tag_q[head + PTR_BITS'(k)] == push_tag &&
          !(state == WRITE && k == 0)) begin
        merge     = 1'b1;
        merge_idx = head + PTR_BITS'(k);
      end
    end
  end

  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PTR_BITS+1)'(k) < count &&
          tag_q[head + PTR_BITS'(k)] == look_tag) begin
        lookupHit  = 1'b1;
        lookupData = data_q[head + PTR_BITS'(k)];
      end
    end
  end

  assign do_merge = pushE && merge;
  assign do_new   = pushE && !merge && !full;
  assign pop      = (state == WRITE) && wDone;

  assign count_nx = count
                  + {{PTR_BITS{1'b0}}, do_new}
                  - {{PTR_BITS{1'b0}}, pop};

  // A merge into the head on the launch edge must reach memory.
  assign head_data = (do_merge && merge_idx == head) ?
                     pushData : data_q[head];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (count != '0) state_nx = WRITE;
      WRITE:   if (wDone) state_nx = GAP;
      GAP:     state_nx = (count != '0) ? WRITE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_new) begin
      tag_q[tail]  <= push_tag;
      data_q[tail] <= pushData;
    end else if (do_merge) begin
      data_q[merge_idx] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      wE    <= 1'b0;
      wAddr <= '0;
      wData <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      state <= state_nx;
      count <= count_nx;
      full  <= (count_nx == (PTR_BITS+1)'(DEPTH));
      empty <= (count_nx == '0) && (state_nx == IDLE);
      if (do_new) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      if (state_nx == WRITE && state != WRITE) begin
        wE    <= 1'b1;
        wAddr <= {tag_q[head], {OFFS_BITS{1'b0}}};
        wData <= head_data;
      end else if (state_nx != WRITE) begin
        wE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed cycle-table bench for mem_write_buffer.
// Hand sequence covers async reset mid-write.
module tb_mem_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         pushE;
  logic [31:0]  pushAddr;
  logic [127:0] pushData;
  logic         full;
  logic         empty;
  logic [31:0]  lookupAddr;
  logic         lookupHit;
  logic [127:0] lookupData;
  logic [31:0]  wAddr;
  logic         wE;
  logic [127:0] wData;
  logic         wDone;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_write_buffer dut (
    .clk(clk),
    .rst(rst),
    .pushE(pushE),
    .pushAddr(pushAddr),
    .pushData(pushData),
    .full(full),
    .empty(empty),
    .lookupAddr(lookupAddr),
    .lookupHit(lookupHit),
    .lookupData(lookupData),
    .wAddr(wAddr),
    .wE(wE),
    .wData(wData),
    .wDone(wDone)
  );

  typedef struct {
    logic         pe;
    logic [31:0]  pa;
    logic [127:0] pd;
    logic [31:0]  la;
    logic         wd;
    logic         ewe;
    logic [31:0]  ewa;
    logic [127:0] ewd;
    logic         ef;
    logic         eem;
    logic         ehit;
    logic [127:0] eld;
  } vec_t;

  vec_t tv[$];

  localparam logic [31:0] NOHIT = 32'hFFFF_FF00;

  function automatic logic [127:0] dat(input int n);
    return {4{32'hDA7A_0000 + n}};
  endfunction

  task automatic add(input logic pe, input logic [31:0] pa,
                     input logic [127:0] pd, input logic [31:0] la,
                     input logic wd, input logic ewe,
                     input logic [31:0] ewa, input logic [127:0] ewd,
                     input logic ef, input logic eem,
                     input logic ehit, input logic [127:0] eld);
    vec_t v;
    v.pe = pe; v.pa = pa; v.pd = pd; v.la = la; v.wd = wd;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    v.ef = ef; v.eem = eem; v.ehit = ehit; v.eld = eld;
    tv.push_back(v);
  endtask

  task automatic drive(input logic pe, input logic [31:0] pa,
                       input logic [127:0] pd, input logic [31:0] la,
                       input logic wd);
    pushE = pe; pushAddr = pa; pushData = pd;
    lookupAddr = la; wDone = wd;
  endtask

  task automatic check1(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected values: D-index per line
  // 0:0x128 1-5:0x100..0x500 6:B0 7:D1 8:D2 9:D3 10:D4 11:D5
  task automatic build;
    add(1,'h128,dat(0),'h120,0, 0,0,0, 0,0, 1,dat(0));
    add(0,0,0,'h120,0, 1,'h120,dat(0), 0,0, 1,dat(0));
    add(0,0,0,'h120,0, 1,'h120,dat(0), 0,0, 1,dat(0));
    add(0,0,0,'h120,0, 1,'h120,dat(0), 0,0, 1,dat(0));
    add(0,0,0,'h120,0, 1,'h120,dat(0), 0,0, 1,dat(0));
    add(0,0,0,'h120,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 0,0,0, 0,1, 0,0);
    add(1,'h100,dat(1),NOHIT,0, 0,0,0, 0,0, 0,0);
    add(1,'h200,dat(2),NOHIT,0, 1,'h100,dat(1), 0,0, 0,0);
    add(1,'h300,dat(3),NOHIT,0, 1,'h100,dat(1), 0,0, 0,0);
    add(1,'h400,dat(4),NOHIT,0, 1,'h100,dat(1), 1,0, 0,0);
    add(1,'h500,dat(5),'h500,0, 1,'h100,dat(1), 1,0, 0,0);
    add(1,'h500,dat(5),'h500,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,1, 1,'h200,dat(2), 0,0, 0,0);
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h300,dat(3), 0,0, 0,0);
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h400,dat(4), 0,0, 0,0);
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 0,0,0, 0,1, 0,0);
    add(1,'h100,dat(6),NOHIT,0, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h100,dat(6), 0,0, 0,0);
    add(1,'h200,dat(7),NOHIT,0, 1,'h100,dat(6), 0,0, 0,0);
    add(1,'h20C,dat(8),'h204,0, 1,'h100,dat(6), 0,0, 1,dat(8));
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h200,dat(8), 0,0, 0,0);
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 0,0,0, 0,1, 0,0);
    add(1,'h340,dat(9),'h348,0, 0,0,0, 0,0, 1,dat(9));
    add(0,0,0,'h348,0, 1,'h340,dat(9), 0,0, 1,dat(9));
    add(0,0,0,'h348,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 0,0,0, 0,1, 0,0);
    add(1,'h400,dat(10),NOHIT,0, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h400,dat(10), 0,0, 0,0);
    add(1,'h400,dat(11),'h400,0, 1,'h400,dat(10), 0,0, 1,dat(11));
    add(0,0,0,'h400,1, 0,0,0, 0,0, 1,dat(11));
    add(0,0,0,NOHIT,1, 1,'h400,dat(11), 0,0, 0,0);
    add(0,0,0,NOHIT,0, 1,'h400,dat(11), 0,0, 0,0);
    add(0,0,0,NOHIT,1, 0,0,0, 0,0, 0,0);
    add(0,0,0,NOHIT,0, 0,0,0, 0,1, 0,0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, NOHIT, 0);
    build();
    #12;
    check1("rst_wE", 128'(wE), 128'(1'b0));
    check1("rst_empty", 128'(empty), 128'(1'b1));
    check1("rst_full", 128'(full), 128'(1'b0));
    check1("rst_wAddr", 128'(wAddr), 128'(0));
    check1("rst_wData", wData, 128'(0));

    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h100, dat(1), NOHIT, 0);
    @(negedge clk);
    drive(1, 32'h200, dat(2), NOHIT, 0);
    @(posedge clk);
    #1;
    check1("pre_rst_wE", 128'(wE), 128'(1'b1));
    drive(0, 0, 0, 32'h100, 0);
    #2;
    rst = 1'b0;
    #1;
    check1("async_rst_wE", 128'(wE), 128'(1'b0));
    check1("async_rst_empty", 128'(empty), 128'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("post_rst_empty", 128'(empty), 128'(1'b1));
    check1("post_rst_full", 128'(full), 128'(1'b0));
    check1("post_rst_hit", 128'(lookupHit), 128'(1'b0));
    check1("post_rst_wE", 128'(wE), 128'(1'b0));

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].pe, tv[i].pa, tv[i].pd, tv[i].la, tv[i].wd);
      @(posedge clk);
      #1;
      tests++;
      if (wE !== tv[i].ewe || full !== tv[i].ef ||
          empty !== tv[i].eem || lookupHit !== tv[i].ehit ||
          lookupData !== tv[i].eld ||
          (tv[i].ewe && (wAddr !== tv[i].ewa || wData !== tv[i].ewd))) begin
        fails++;
        $display("FAIL vec%0d: got wE=%b full=%b empty=%b hit=%b wAddr=%h ld=%h wd=%h want wE=%b full=%b empty=%b hit=%b wAddr=%h ld=%h wd=%h",
                 i, wE, full, empty, lookupHit, wAddr, lookupData, wData,
                 tv[i].ewe, tv[i].ef, tv[i].eem, tv[i].ehit, tv[i].ewa,
                 tv[i].eld, tv[i].ewd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
